bus_timer: RTL

BUS_TIMER -- requirements
Module: bus_timer

---
 rtl/bus_timer_pkg.sv | 47 ++++
 rtl/bus_timer.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/bus_timer_pkg.sv
// Shared definitions for the bus_timer block: register offsets, CTRL field
// positions, MODE encodings, FSM state encoding and a byte-merge helper.
package bus_timer_pkg;

    // Byte offsets of the registers inside one timer instance
    localparam logic [31:0] OFFSET_CTRL   = 32'h0000_0000;
    localparam logic [31:0] OFFSET_PRESET = 32'h0000_0004;
    localparam logic [31:0] OFFSET_COUNT  = 32'h0000_0008;

    // Word indices as decoded from addr[3:2]
    localparam logic [1:0] REG_CTRL   = OFFSET_CTRL[3:2];
    localparam logic [1:0] REG_PRESET = OFFSET_PRESET[3:2];
    localparam logic [1:0] REG_COUNT  = OFFSET_COUNT[3:2];

    // CTRL bit positions
    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_MODE_LSB = 1;
    localparam int CTRL_MODE_MSB = 2;
    localparam int CTRL_IM_BIT   = 3;

    // MODE encodings; anything other than auto-reload behaves as one-shot
    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

    // Counter FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_t;

    // Replace the bytes of old_val selected by byteen with those of new_val
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  byteen);
        logic [31:0] result;
        result = old_val;
        for (int i = 0; i < 4; i++) begin
            if (byteen[i]) begin
                result[i*8 +: 8] = new_val[i*8 +: 8];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/bus_timer.sv
// bus_timer: memory-mapped down-counting timer with CTRL / PRESET / COUNT
// registers and a maskable interrupt. Auto-reload mode (MODE=01) exists only
// when the macro BUS_TIMER_RELOAD_EN is defined; otherwise MODE reads 0 and
// every expiry is one-shot.
module bus_timer
    import bus_timer_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [3:0]  byteen,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    state_t      state_q, state_d;
    logic        en_q, en_d;
    logic [1:0]  mode_q, mode_d;
    logic        im_q, im_d;
    logic [31:0] preset_q, preset_d;
    logic [31:0] count_q, count_d;
    logic        irq_flag_q, irq_flag_d;

    logic        ctrl_wr;
    logic        preset_wr;
    logic        reload_mode;
    logic [1:0]  mode_wr_val;
    logic        unused_addr_bits;

    // Only addr[3:2] selects a register; the bridge has already decoded the rest
    assign unused_addr_bits = ^{addr[31:4], addr[1:0]};

    // CTRL contents live entirely in byte 0, so only that lane makes a CTRL write
    assign ctrl_wr   = we && (addr[3:2] == REG_CTRL) && byteen[0];
    assign preset_wr = we && (addr[3:2] == REG_PRESET);

`ifdef BUS_TIMER_RELOAD_EN
    assign reload_mode = (mode_q == MODE_RELOAD);
    assign mode_wr_val = wdata[CTRL_MODE_MSB:CTRL_MODE_LSB];
`else
    assign reload_mode = 1'b0;
    assign mode_wr_val = MODE_ONESHOT;
`endif

    // Next-state logic: FSM step first, then bus writes override it
    always_comb begin
        state_d    = state_q;
        en_d       = en_q;
        mode_d     = mode_q;
        im_d       = im_q;
        preset_d   = preset_q;
        count_d    = count_q;
        irq_flag_d = irq_flag_q;

        case (state_q)
            ST_IDLE: begin
                if (en_q) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                count_d = preset_q;
                state_d = ST_CNT;
            end
            ST_CNT: begin
                if (!en_q) begin
                    state_d = ST_IDLE;
                end else if (count_q > 32'd1) begin
                    count_d = count_q - 32'd1;
                end else begin
                    count_d    = 32'd0;
                    irq_flag_d = 1'b1;
                    state_d    = ST_INT;
                end
            end
            ST_INT: begin
                if (reload_mode) begin
                    irq_flag_d = 1'b0;
                end else begin
                    en_d = 1'b0;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (ctrl_wr) begin
            en_d       = wdata[CTRL_EN_BIT];
            mode_d     = mode_wr_val;
            im_d       = wdata[CTRL_IM_BIT];
            irq_flag_d = 1'b0;
            state_d    = ST_IDLE;
        end

        if (preset_wr) begin
            preset_d = merge_bytes(preset_q, wdata, byteen);
        end
    end

    // State and register storage, cleared asynchronously by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            en_q       <= 1'b0;
            mode_q     <= MODE_ONESHOT;
            im_q       <= 1'b0;
            preset_q   <= 32'd0;
            count_q    <= 32'd0;
            irq_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            en_q       <= en_d;
            mode_q     <= mode_d;
            im_q       <= im_d;
            preset_q   <= preset_d;
            count_q    <= count_d;
            irq_flag_q <= irq_flag_d;
        end
    end

    // Combinational register read; the reserved offset returns zero
    always_comb begin
        rdata = 32'd0;
        case (addr[3:2])
            REG_CTRL: begin
                rdata[CTRL_EN_BIT]                 = en_q;
                rdata[CTRL_MODE_MSB:CTRL_MODE_LSB] = mode_q;
                rdata[CTRL_IM_BIT]                 = im_q;
            end
            REG_PRESET: rdata = preset_q;
            REG_COUNT:  rdata = count_q;
            default:    rdata = 32'd0;
        endcase
    end

    assign irq = im_q & irq_flag_q;

endmodule
